// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg
// Shared types and constants for the UART TX scheduler:
//   state_t   - scheduler FSM state encoding (3 bits)
//   src_t     - requester identity used by the arbiter
//   ALU_BYTES / REG_BYTES - frame lengths in bytes per requester
package uart_tx_sched_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND    = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    GAP     = 3'd4
  } state_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_REG = 1'b1
  } src_t;

  localparam logic [1:0] ALU_BYTES = 2'd2;
  localparam logic [1:0] REG_BYTES = 2'd1;

endpackage

// File: rtl/uart_tx_rr_arb.sv
// uart_tx_rr_arb
// Two-way round-robin arbiter between the ALU and register-read requesters.
// Ports:
//   CLK, RST     - clock, asynchronous active-low reset
//   alu_req      - ALU frame request
//   reg_req      - register-read frame request
//   update       - strobe from the FSM: the current grant was taken
//   grant        - winning source (meaningful only when grant_valid)
//   grant_valid  - at least one request is pending
// last_grant resets to SRC_REG so the ALU wins the first tie.
module uart_tx_rr_arb
  import uart_tx_sched_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic alu_req,
  input  logic reg_req,
  input  logic update,
  output src_t grant,
  output logic grant_valid
);

  src_t last_grant;

  always_comb begin
    grant = SRC_ALU;
    if (alu_req && reg_req) begin
      grant = (last_grant == SRC_ALU) ? SRC_REG : SRC_ALU;
    end else if (reg_req) begin
      grant = SRC_REG;
    end
  end

  assign grant_valid = alu_req | reg_req;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      last_grant <= SRC_REG;
    end else if (update) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Accepts whole frames from the ALU (2 bytes, low byte first) and the
// register-read path (1 byte), arbitrates round-robin, and feeds bytes to the
// UART transmitter one at a time.
// Ports:
//   CLK, RST              - TX-domain clock, asynchronous active-low reset
//   alu_req/alu_data      - ALU frame request and 2-byte payload
//   alu_ack               - one-cycle pulse: ALU frame captured
//   reg_req/reg_data      - register-read frame request and 1-byte payload
//   reg_ack               - one-cycle pulse: register frame captured
//   tx_busy               - UART TX busy
//   tx_data, tx_valid     - byte and one-cycle Data_valid pulse to UART TX
//   sched_busy            - high whenever the FSM is not IDLE
//   err_timeout           - one-cycle pulse: frame aborted, tx_busy never rose
//   dbg_state             - current FSM state
// Handshakes: a requester holds req high with data stable until it sees its
// ack pulse, then drops req the next cycle; requests are only sampled in IDLE.
// Toward the UART, tx_valid is a single-cycle pulse with tx_data stable; the
// byte is considered accepted once tx_busy rises and finished once it falls.
// All outputs come from registers or decoded registered state.
module uart_tx_scheduler
  import uart_tx_sched_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int GAP_CYCLES   = 1,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    alu_req,
  input  logic [2*DATA_WIDTH-1:0] alu_data,
  output logic                    alu_ack,
  input  logic                    reg_req,
  input  logic [DATA_WIDTH-1:0]   reg_data,
  output logic                    reg_ack,
  input  logic                    tx_busy,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_valid,
  output logic                    sched_busy,
  output logic                    err_timeout,
  output logic [2:0]              dbg_state
);

  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);
  localparam logic [7:0] TO_LOAD  = 8'(BUSY_TIMEOUT);

  state_t                  state;
  logic [2*DATA_WIDTH-1:0] hold;
  logic [1:0]              byte_cnt;
  // Shared down counter: busy timeout in WAIT_HI, inter-byte gap in GAP.
  logic [7:0]              cnt;
  src_t                    grant;
  logic                    grant_valid;
  logic                    grant_take;

  assign grant_take = (state == IDLE) && grant_valid;
  assign sched_busy = (state != IDLE);
  assign dbg_state  = state;

  uart_tx_rr_arb u_arb (
    .CLK         (CLK),
    .RST         (RST),
    .alu_req     (alu_req),
    .reg_req     (reg_req),
    .update      (grant_take),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      hold        <= '0;
      byte_cnt    <= '0;
      cnt         <= '0;
      alu_ack     <= 1'b0;
      reg_ack     <= 1'b0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      err_timeout <= 1'b0;
    end else begin
      alu_ack     <= 1'b0;
      reg_ack     <= 1'b0;
      tx_valid    <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            if (grant == SRC_ALU) begin
              hold     <= alu_data;
              byte_cnt <= ALU_BYTES;
              tx_data  <= alu_data[DATA_WIDTH-1:0];
              alu_ack  <= 1'b1;
            end else begin
              hold     <= {{DATA_WIDTH{1'b0}}, reg_data};
              byte_cnt <= REG_BYTES;
              tx_data  <= reg_data;
              reg_ack  <= 1'b1;
            end
            tx_valid <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          cnt   <= TO_LOAD;
          state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (tx_busy) begin
            cnt   <= '0;
            state <= WAIT_LO;
          end else if (cnt <= 8'd1) begin
            // Last allowed cycle without busy: drop the rest of the frame.
            cnt         <= '0;
            byte_cnt    <= '0;
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            byte_cnt <= byte_cnt - 2'd1;
            hold     <= hold >> DATA_WIDTH;
            tx_data  <= hold[2*DATA_WIDTH-1:DATA_WIDTH];
            if (GAP_CYCLES == 0) begin
              // No gap: decide next step here using the pre-decrement count.
              cnt <= '0;
              if (byte_cnt > 2'd1) begin
                tx_valid <= 1'b1;
                state    <= SEND;
              end else begin
                state <= IDLE;
              end
            end else begin
              cnt   <= GAP_LOAD;
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (cnt <= 8'd1) begin
            cnt <= '0;
            if (byte_cnt != 2'd0) begin
              tx_valid <= 1'b1;
              state    <= SEND;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
